// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: state codes,
// opcodes, datapath select encodings, trap causes and the control-word layout.
package riscv_ctrl_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEMADR    = 4'd2;
    localparam logic [3:0] S_MEMREAD   = 4'd3;
    localparam logic [3:0] S_MEMWB     = 4'd4;
    localparam logic [3:0] S_MEMWRITE  = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_EXEC_I    = 4'd7;
    localparam logic [3:0] S_ALUWB     = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;
    localparam logic [3:0] S_JALR      = 4'd11;
    localparam logic [3:0] S_JALR_LINK = 4'd12;
    localparam logic [3:0] S_LUI       = 4'd13;
    localparam logic [3:0] S_AUIPC     = 4'd14;
    localparam logic [3:0] S_TRAP      = 4'd15;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;
    localparam logic [2:0] ALU_PASS_B = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ECALL   = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] result_src;
    } ctrl_t;

    // States that hold a memory request open and therefore run the wait counter.
    function automatic logic is_mem_state(input logic [3:0] st);
        logic r;
        case (st)
            S_FETCH, S_MEMREAD, S_MEMWRITE: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_alu_dec.sv
// ALU operation decoder shared by the register and immediate execute states;
// flags funct3 values this core does not implement.
module riscv_alu_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       itype,
    output logic [2:0] alu_control,
    output logic       illegal
);

    // Immediate forms implement ADDI only; instr[30] is an immediate bit there, never SUB.
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        if (itype) begin
            if (funct3 != F3_ADDSUB) begin
                illegal = 1'b1;
            end else begin
                alu_control = ALU_ADD;
            end
        end else begin
            case (funct3)
                F3_ADDSUB: alu_control = funct7b5 ? ALU_SUB : ALU_ADD;
                F3_AND:    alu_control = ALU_AND;
                F3_OR:     alu_control = ALU_OR;
                default:   illegal     = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RV32I datapath: per-state control words,
// ready/timeout handshake on the shared memory, and a sticky trap.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int STATE_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         result_src,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [STATE_W-1:0] dbg_state
);

    localparam int              WAIT_W     = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam bit              TIMEOUT_EN = (MAX_WAIT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : '0;
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = '1;

    logic [3:0]        state_r;
    logic [3:0]        state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              trap_r;
    logic [1:0]        trap_cause_r;
    logic [1:0]        trap_cause_next_s;
    ctrl_t             ctrl_s;
    logic [2:0]        dec_alu_s;
    logic              dec_illegal_s;
    logic              dec_itype_s;
    logic              timeout_s;

    assign dec_itype_s = (state_r == S_EXEC_I);

    riscv_alu_dec u_alu_dec (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .itype       (dec_itype_s),
        .alu_control (dec_alu_s),
        .illegal     (dec_illegal_s)
    );

    // A ready arriving on the last allowed cycle still wins over the timeout.
    assign timeout_s = TIMEOUT_EN && is_mem_state(state_r) && !mem_ready
                       && (wait_cnt_r == WAIT_LAST);

    // Control word and next-state selection for the current state.
    always_comb begin
        ctrl_s            = '0;
        state_next_s      = state_r;
        trap_cause_next_s = trap_cause_r;
        case (state_r)
            S_FETCH: begin
                ctrl_s.mem_req     = 1'b1;
                ctrl_s.adr_src     = 1'b0;
                ctrl_s.alu_src_a   = SRCA_PC;
                ctrl_s.alu_src_b   = SRCB_FOUR;
                ctrl_s.alu_control = ALU_ADD;
                ctrl_s.result_src  = RES_ALURESULT;
                if (mem_ready) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_write = 1'b1;
                    state_next_s    = S_DECODE;
                end else if (timeout_s) begin
                    state_next_s      = S_TRAP;
                    trap_cause_next_s = CAUSE_TIMEOUT;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                ctrl_s.alu_src_a   = SRCA_OLDPC;
                ctrl_s.alu_src_b   = SRCB_IMM;
                ctrl_s.alu_control = ALU_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
                    OP_R:              state_next_s = S_EXEC_R;
                    OP_I:              state_next_s = S_EXEC_I;
                    OP_BRANCH:         state_next_s = S_BRANCH;
                    OP_JAL:            state_next_s = S_JAL;
                    OP_JALR:           state_next_s = S_JALR;
                    OP_LUI:            state_next_s = S_LUI;
                    OP_AUIPC:          state_next_s = S_AUIPC;
                    OP_SYSTEM: begin
                        state_next_s      = S_TRAP;
                        trap_cause_next_s = CAUSE_ECALL;
                    end
                    default: begin
                        state_next_s      = S_TRAP;
                        trap_cause_next_s = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl_s.alu_src_a   = SRCA_RS1;
                ctrl_s.alu_src_b   = SRCB_IMM;
                ctrl_s.alu_control = ALU_ADD;
                if (opcode == OP_STORE) begin
                    state_next_s = S_MEMWRITE;
                end else begin
                    state_next_s = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.adr_src = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_MEMWB;
                end else if (timeout_s) begin
                    state_next_s      = S_TRAP;
                    trap_cause_next_s = CAUSE_TIMEOUT;
                end else begin
                    state_next_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                ctrl_s.result_src = RES_MEMDATA;
                ctrl_s.reg_write  = 1'b1;
                state_next_s      = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl_s.mem_req   = 1'b1;
                ctrl_s.mem_write = 1'b1;
                ctrl_s.adr_src   = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_FETCH;
                end else if (timeout_s) begin
                    state_next_s      = S_TRAP;
                    trap_cause_next_s = CAUSE_TIMEOUT;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_EXEC_R, S_EXEC_I: begin
                ctrl_s.alu_src_a   = SRCA_RS1;
                ctrl_s.alu_src_b   = (state_r == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                ctrl_s.alu_control = dec_alu_s;
                if (dec_illegal_s) begin
                    state_next_s      = S_TRAP;
                    trap_cause_next_s = CAUSE_ILLEGAL;
                end else begin
                    state_next_s = S_ALUWB;
                end
            end
            S_ALUWB: begin
                ctrl_s.result_src = RES_ALUOUT;
                ctrl_s.reg_write  = 1'b1;
                state_next_s      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_s.alu_src_a   = SRCA_RS1;
                ctrl_s.alu_src_b   = SRCB_RS2;
                ctrl_s.alu_control = ALU_SUB;
                ctrl_s.result_src  = RES_ALUOUT;
                if (funct3 == F3_BEQ) begin
                    ctrl_s.pc_write = zero;
                    state_next_s    = S_FETCH;
                end else if (funct3 == F3_BNE) begin
                    ctrl_s.pc_write = ~zero;
                    state_next_s    = S_FETCH;
                end else begin
                    state_next_s      = S_TRAP;
                    trap_cause_next_s = CAUSE_ILLEGAL;
                end
            end
            S_JAL: begin
                // ALUOut already holds the target from DECODE; this cycle forms the link value.
                ctrl_s.alu_src_a   = SRCA_OLDPC;
                ctrl_s.alu_src_b   = SRCB_FOUR;
                ctrl_s.alu_control = ALU_ADD;
                ctrl_s.result_src  = RES_ALUOUT;
                ctrl_s.pc_write    = 1'b1;
                state_next_s       = S_ALUWB;
            end
            S_JALR: begin
                ctrl_s.alu_src_a   = SRCA_RS1;
                ctrl_s.alu_src_b   = SRCB_IMM;
                ctrl_s.alu_control = ALU_ADD;
                ctrl_s.result_src  = RES_ALURESULT;
                ctrl_s.pc_write    = 1'b1;
                state_next_s       = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                ctrl_s.alu_src_a   = SRCA_OLDPC;
                ctrl_s.alu_src_b   = SRCB_FOUR;
                ctrl_s.alu_control = ALU_ADD;
                ctrl_s.result_src  = RES_ALURESULT;
                ctrl_s.reg_write   = 1'b1;
                state_next_s       = S_FETCH;
            end
            S_LUI: begin
                ctrl_s.alu_src_a   = SRCA_ZERO;
                ctrl_s.alu_src_b   = SRCB_IMM;
                ctrl_s.alu_control = ALU_PASS_B;
                state_next_s       = S_ALUWB;
            end
            S_AUIPC: begin
                ctrl_s.alu_src_a   = SRCA_OLDPC;
                ctrl_s.alu_src_b   = SRCB_IMM;
                ctrl_s.alu_control = ALU_ADD;
                state_next_s       = S_ALUWB;
            end
            S_TRAP: begin
                state_next_s = S_TRAP;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counts unacknowledged request cycles; saturates so a disabled timeout never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (ctrl_s.mem_req && !mem_ready && (state_next_s == state_r)) begin
            if (wait_cnt_r != WAIT_SAT) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // Sticky trap flag and cause, captured on the edge that enters TRAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_r       <= 1'b0;
            trap_cause_r <= CAUSE_NONE;
        end else begin
            trap_r       <= (state_next_s == S_TRAP);
            trap_cause_r <= trap_cause_next_s;
        end
    end

    // Enables are forced low while reset is asserted so nothing commits in that cycle.
    assign mem_req     = ctrl_s.mem_req   & ~reset;
    assign mem_write   = ctrl_s.mem_write & ~reset;
    assign ir_write    = ctrl_s.ir_write  & ~reset;
    assign pc_write    = ctrl_s.pc_write  & ~reset;
    assign reg_write   = ctrl_s.reg_write & ~reset;
    assign adr_src     = ctrl_s.adr_src;
    assign alu_src_a   = ctrl_s.alu_src_a;
    assign alu_src_b   = ctrl_s.alu_src_b;
    assign alu_control = ctrl_s.alu_control;
    assign result_src  = ctrl_s.result_src;
    assign trap        = trap_r;
    assign trap_cause  = trap_cause_r;
    assign dbg_state   = STATE_W'(state_r);

endmodule
